// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared types and frame constants for the instruction memory loader
//
// Purpose: state enum for the loader FSM and the fixed frame geometry.
// Ports: none (package).
package imem_loader_pkg;

  typedef enum logic [2:0] {
    S_CNT0  = 3'd0,
    S_CNT1  = 3'd1,
    S_DATA  = 3'd2,
    S_WRITE = 3'd3,
    S_CSUM  = 3'd4,
    S_DONE  = 3'd5,
    S_ERR   = 3'd6
  } state_t;

  localparam int CNT_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// rtl/imem_loader_byte_packer.sv - assembles little-endian bytes into a 32-bit word
//
// Purpose: writes each loaded byte into its byte lane of a 32-bit word register.
// Ports:
//   clk     - clock
//   rst     - synchronous active-low reset (word clears to 0)
//   load    - write byte_in into lane this edge
//   lane    - byte lane, 0 = bits [7:0]
//   byte_in - byte to store
//   word    - assembled word
module byte_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [1:0]  lane,
  input  logic [7:0]  byte_in,
  output logic [31:0] word
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      word <= 32'h0;
    end else if (load) begin
      word[{lane, 3'b000} +: 8] <= byte_in;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - loads a checksummed byte frame into instruction memory
//
// Purpose: receives CNT_LO, CNT_HI, 4*N data bytes and a CSUM byte, writes the
// N words to imem from BASE_ADDR upward and releases the core only when the
// checksum matches.
// Ports:
//   clk, rst               - clock, synchronous active-low reset
//   rx_valid/rx_data/rx_ready - byte stream handshake
//   mem_addr/mem_data      - imem write address (word aligned) and data
//   mem_wr, mem_en         - one-cycle write strobe (identical)
//   cpu_hold               - 1 keeps the core in reset
//   done, error            - sticky completion / failure flags
//   words_loaded           - words written so far
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int          MAX_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_data,
  output logic        mem_wr,
  output logic        mem_en,
  output logic        cpu_hold,
  output logic        done,
  output logic        error,
  output logic [15:0] words_loaded
);

  localparam logic [16:0] MAX_W = 17'(MAX_WORDS);

  state_t      state, state_next;
  logic [7:0]  cnt_lo;
  logic [15:0] count;
  logic [7:0]  sum;
  logic [1:0]  byte_idx;
  logic        accept;

  assign accept = rx_valid && rx_ready;

  // All outputs decode from state or come straight from registers.
  assign rx_ready = (state == S_CNT0) || (state == S_CNT1) ||
                    (state == S_DATA) || (state == S_CSUM);
  assign mem_wr   = (state == S_WRITE);
  assign mem_en   = mem_wr;
  assign done     = (state == S_DONE);
  assign error    = (state == S_ERR);
  assign cpu_hold = (state != S_DONE);
  assign mem_addr = BASE_ADDR + {14'd0, words_loaded, 2'b00};

  byte_packer u_packer (
    .clk     (clk),
    .rst     (rst),
    .load    (accept && (state == S_DATA)),
    .lane    (byte_idx),
    .byte_in (rx_data),
    .word    (mem_data)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= S_CNT0;
      cnt_lo       <= 8'h0;
      count        <= 16'h0;
      sum          <= 8'h0;
      byte_idx     <= 2'd0;
      words_loaded <= 16'h0;
    end else begin
      state <= state_next;
      // The checksum byte itself is never folded into the running sum.
      if (accept && (state != S_CSUM)) begin
        sum <= sum + rx_data;
      end
      if (accept && (state == S_CNT0)) begin
        cnt_lo <= rx_data;
      end
      if (accept && (state == S_CNT1)) begin
        count <= {rx_data, cnt_lo};
      end
      if (accept && (state == S_DATA)) begin
        byte_idx <= byte_idx + 2'd1;
      end
      if (state == S_WRITE) begin
        words_loaded <= words_loaded + 16'd1;
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_CNT0: begin
        if (accept) state_next = S_CNT1;
      end
      S_CNT1: begin
        if (accept) begin
          if ({1'b0, rx_data, cnt_lo} > MAX_W) state_next = S_ERR;
          else if ({rx_data, cnt_lo} == 16'h0) state_next = S_CSUM;
          else state_next = S_DATA;
        end
      end
      S_DATA: begin
        if (accept && (byte_idx == 2'(BYTES_PER_WORD - 1))) state_next = S_WRITE;
      end
      S_WRITE: begin
        // words_loaded still holds the pre-increment value here.
        if ((words_loaded + 16'd1) == count) state_next = S_CSUM;
        else state_next = S_DATA;
      end
      S_CSUM: begin
        if (accept) state_next = (rx_data == sum) ? S_DONE : S_ERR;
      end
      S_DONE:  state_next = S_DONE;
      S_ERR:   state_next = S_ERR;
      default: state_next = S_ERR;
    endcase
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - randomized scoreboard bench for imem_loader
module tb_imem_loader;

  localparam logic [31:0] BASE = 32'h0;
  localparam int          MAXW = 1024;

  logic        clk;
  logic        rst;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_data;
  logic        mem_wr;
  logic        mem_en;
  logic        cpu_hold;
  logic        done;
  logic        error;
  logic [15:0] words_loaded;

  imem_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .rx_ready     (rx_ready),
    .mem_addr     (mem_addr),
    .mem_data     (mem_data),
    .mem_wr       (mem_wr),
    .mem_en       (mem_en),
    .cpu_hold     (cpu_hold),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_q[$];
  logic [31:0] frame_words[$];
  int          compared   = 0;
  int          mismatched = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe is matched against the oldest expected write.
  always @(posedge clk) begin
    #1;
    if (mem_wr === 1'b1) begin
      check("mem_en_equals_mem_wr", {31'd0, mem_en}, 32'd1);
      check("rx_ready_in_write", {31'd0, rx_ready}, 32'd0);
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_write: got addr %h data %h expected no write", mem_addr, mem_data);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("write_addr", mem_addr, e.addr);
        check("write_data", mem_data, e.data);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int idle_pct, output bit ok);
    int t;
    bit acc;
    ok = 1'b0;
    t  = 0;
    while (t < 300 && !ok) begin
      @(negedge clk);
      if (int'($urandom_range(99)) < idle_pct) begin
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
      end else begin
        rx_valid = 1'b1;
        rx_data  = b;
      end
      acc = rx_valid && rx_ready;
      @(posedge clk);
      t++;
      if (acc) ok = 1'b1;
    end
    if (!ok) begin
      compared++;
      mismatched++;
      $display("FAIL handshake_timeout: byte %h not accepted within 300 cycles", b);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst      = 1'b0;
    rx_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_rx_ready"}, {31'd0, rx_ready}, 32'd1);
    check({tag, "_mem_wr"}, {31'd0, mem_wr}, 32'd0);
    check({tag, "_mem_en"}, {31'd0, mem_en}, 32'd0);
    check({tag, "_mem_addr"}, mem_addr, BASE);
    check({tag, "_mem_data"}, mem_data, 32'd0);
    check({tag, "_cpu_hold"}, {31'd0, cpu_hold}, 32'd1);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
    check({tag, "_error"}, {31'd0, error}, 32'd0);
    check({tag, "_words_loaded"}, {16'd0, words_loaded}, 32'd0);
  endtask

  // Builds the frame from frame_words, sends it and checks the final flags.
  // abort_after >= 0 stops after that many bytes with no final checks.
  task automatic send_frame(input int n, input int csum_delta, input int idle_pct,
                            input int abort_after);
    logic [7:0] bytes[$];
    logic [7:0] s;
    int         nw;
    bit         ok;
    bit         good;
    nw = (n > MAXW) ? 0 : n;
    bytes.push_back(n[7:0]);
    bytes.push_back(n[15:8]);
    for (int j = 0; j < nw; j++) begin
      for (int k = 0; k < 4; k++) bytes.push_back(frame_words[j][8*k +: 8]);
    end
    s = 8'h0;
    foreach (bytes[i]) s = s + bytes[i];
    if (n <= MAXW) bytes.push_back(s + 8'(csum_delta));
    for (int i = 0; i < bytes.size(); i++) begin
      if (abort_after >= 0 && i == abort_after) break;
      send_byte(bytes[i], idle_pct, ok);
      if (!ok) return;
      if (i >= 2 && i < 2 + 4 * nw && ((i - 2) % 4) == 3) begin
        wr_t e;
        e.addr = BASE + 32'(4 * ((i - 2) / 4));
        e.data = frame_words[(i - 2) / 4];
        exp_q.push_back(e);
      end
    end
    if (abort_after >= 0) return;
    #1;
    rx_valid = 1'b0;
    good = (csum_delta % 256) == 0;
    if (n > MAXW) begin
      check("oversize_error", {31'd0, error}, 32'd1);
      check("oversize_rx_ready", {31'd0, rx_ready}, 32'd0);
      check("oversize_cpu_hold", {31'd0, cpu_hold}, 32'd1);
      check("oversize_words", {16'd0, words_loaded}, 32'd0);
    end else begin
      check("final_done", {31'd0, done}, {31'd0, good});
      check("final_error", {31'd0, error}, {31'd0, !good});
      check("final_cpu_hold", {31'd0, cpu_hold}, {31'd0, !good});
      check("final_rx_ready", {31'd0, rx_ready}, 32'd0);
      check("final_words_loaded", {16'd0, words_loaded}, 32'(nw));
    end
    // Bytes offered after the end must be ignored.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      rx_valid = 1'b1;
      rx_data  = 8'($urandom);
    end
    @(negedge clk);
    rx_valid = 1'b0;
    @(posedge clk);
    #1;
    check("pending_writes", 32'(exp_q.size()), 32'd0);
    if (n <= MAXW) check("sticky_done", {31'd0, done}, {31'd0, good});
    check("sticky_error", {31'd0, error}, {31'd0, (n > MAXW) || !good});
    check("sticky_words_loaded", {16'd0, words_loaded}, 32'(nw));
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst      = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("reset");
    @(negedge clk);
    rst = 1'b1;

    // Two known words, good checksum.
    frame_words = '{32'h00500093, 32'h00100113};
    send_frame(2, 0, 0, -1);

    // Same frame, checksum off by one.
    do_reset();
    send_frame(2, 1, 0, -1);

    // Empty image.
    do_reset();
    frame_words.delete();
    send_frame(0, 0, 0, -1);

    // Count one past the limit.
    do_reset();
    send_frame(MAXW + 1, 0, 0, -1);

    // One word with a bursty valid.
    do_reset();
    frame_words = '{32'($urandom)};
    send_frame(1, 0, 50, -1);

    // Reset arriving during the first write, then a fresh frame.
    do_reset();
    frame_words = '{32'($urandom), 32'($urandom)};
    send_frame(2, 0, 0, 6);
    do_reset();
    #1;
    check_reset_values("midframe_reset");
    frame_words = '{32'($urandom), 32'($urandom)};
    send_frame(2, 0, 20, -1);

    // Random frames, random gaps, random checksum corruption.
    for (int r = 0; r < 6; r++) begin
      do_reset();
      n = int'($urandom_range(1, 6));
      frame_words.delete();
      for (int j = 0; j < n; j++) frame_words.push_back($urandom);
      send_frame(n, ($urandom_range(1) == 0) ? 0 : int'($urandom_range(1, 255)), 30, -1);
    end

    // Largest legal image: last write lands at BASE + 4*(MAXW-1).
    do_reset();
    frame_words.delete();
    for (int j = 0; j < MAXW; j++) frame_words.push_back($urandom);
    send_frame(MAXW, 0, 0, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
